// File: rtl/sample_framer.sv
// Serial sample framer: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Good frames are published on word/word_valid; parity and framing faults raise sticky flags.
module sample_framer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned PARITY_EN      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_in,
    input  logic       ser_en,
    input  logic       err_clr,
    output logic [7:0] word,
    output logic       word_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic [7:0] good_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t     state_q,      state_d;
    logic [2:0] bit_cnt_q,    bit_cnt_d;
    logic [7:0] shift_q,      shift_d;
    logic       par_acc_q,    par_acc_d;
    logic       par_bad_q,    par_bad_d;
    logic [7:0] tmo_q,        tmo_d;
    logic [7:0] word_q,       word_d;
    logic       word_valid_q, word_valid_d;
    logic       parity_err_q, parity_err_d;
    logic       frame_err_q,  frame_err_d;
    logic [7:0] good_count_q, good_count_d;

    logic       perr_set;
    logic       ferr_set;
    logic [7:0] tmo_inc;

    // NOTE: every signal written here is given a default first, so no path
    // leaves it unassigned and no latch is inferred; blocking '=' is correct
    // in combinational logic.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_acc_d    = par_acc_q;
        par_bad_d    = par_bad_q;
        tmo_d        = tmo_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        good_count_d = good_count_q;
        perr_set     = 1'b0;
        ferr_set     = 1'b0;
        tmo_inc      = tmo_q + 8'd1;

        if (state_q == S_IDLE) begin
            tmo_d = 8'd0;
            if (ser_en && !ser_in) begin
                state_d   = S_DATA;
                bit_cnt_d = 3'd0;
                shift_d   = 8'd0;
                par_acc_d = 1'b0;
                par_bad_d = 1'b0;
            end
        end else if (!ser_en) begin
            // Idle gap inside a frame: abort once the gap reaches the limit.
            if (tmo_inc == TMO_LIMIT) begin
                state_d   = S_IDLE;
                tmo_d     = 8'd0;
                bit_cnt_d = 3'd0;
                shift_d   = 8'd0;
                par_acc_d = 1'b0;
                par_bad_d = 1'b0;
                ferr_set  = 1'b1;
            end else begin
                tmo_d = tmo_inc;
            end
        end else begin
            tmo_d = 8'd0;
            case (state_q)
                S_DATA: begin
                    shift_d   = {ser_in, shift_q[7:1]};
                    par_acc_d = par_acc_q ^ ser_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (par_acc_q ^ ser_in) begin
                        par_bad_d = 1'b1;
                        perr_set  = 1'b1;
                    end
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!ser_in) begin
                        ferr_set = 1'b1;
                    end else if (!par_bad_q) begin
                        word_d       = shift_q;
                        word_valid_d = 1'b1;
                        good_count_d = good_count_q + 8'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A fault in the same cycle as err_clr wins, so no event is lost.
        parity_err_d = (parity_err_q & ~err_clr) | perr_set;
        frame_err_d  = (frame_err_q  & ~err_clr) | ferr_set;
    end

    // NOTE: state registers use non-blocking '<=' so all flops update together
    // from values computed before the edge; the shift register is reset too so
    // a frame interrupted by reset can never leak into word.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            par_acc_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            tmo_q        <= 8'd0;
            word_q       <= 8'd0;
            word_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            good_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_acc_q    <= par_acc_d;
            par_bad_q    <= par_bad_d;
            tmo_q        <= tmo_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            good_count_q <= good_count_d;
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign good_count = good_count_q;

endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max idle cycles between bit enables inside a frame (range 1..255).
REQ-002 SHALL have parameter PARITY_EN, default 1: 1 = even-parity bit present in the frame; 0 = no parity bit.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ser_in  input  1  serial data line, sampled only when ser_en=1.
REQ-006 SHALL have port ser_en  input  1  bit-enable tick; one frame bit per cycle with ser_en=1.
REQ-007 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-008 SHALL have port word  output  8  last good sample, {p[7:6],t[5:4],y[3:2],x[1:0]}, drives the moving-average stage's ui_in.
REQ-009 SHALL have port word_valid  output  1  one-cycle pulse when word updates.
REQ-010 SHALL have port parity_err  output  1  sticky parity error flag.
REQ-011 SHALL have port frame_err  output  1  sticky stop-bit or timeout error flag.
REQ-012 SHALL have port good_count  output  8  count of good frames, wraps 255->0.

Function
REQ-013 SHALL frame as: start bit (0), 8 data bits LSB first, parity bit (if PARITY_EN), stop bit (1); bits counted only on ser_en=1 cycles.
REQ-014 SHALL implement states IDLE, DATA, PARITY, STOP; IDLE->DATA on ser_en=1 with ser_in=0; ser_en=1 with ser_in=1 in IDLE ignored.
REQ-015 SHALL go DATA->PARITY (PARITY_EN=1) or DATA->STOP (PARITY_EN=0) after the 8th data bit; PARITY->STOP after the parity bit.
REQ-016 SHALL check even parity: XOR of 8 data bits and parity bit must be 0.
REQ-017 SHALL, on stop bit sampled 1 with parity OK, load word and pulse word_valid for exactly one cycle in the cycle after the stop-bit edge, increment good_count on the same edge, return to IDLE.
REQ-018 SHALL, on parity failure, set parity_err, leave word/good_count unchanged, no word_valid; frame still completes through STOP.
REQ-019 SHALL, on stop bit sampled 0, set frame_err, discard frame, return to IDLE; if parity also failed both flags set.
REQ-020 SHALL hold word stable between word_valid pulses.
REQ-021 SHALL, outside IDLE, count consecutive cycles with ser_en=0; reaching TIMEOUT_CYCLES aborts to IDLE, sets frame_err, discards partial data; counter clears on each ser_en=1 and in IDLE.
REQ-022 SHALL clear parity_err and frame_err on err_clr=1; an error event in the same cycle as err_clr leaves that flag set.
REQ-023 SHALL accept a new start bit on the first ser_en=1 cycle after returning to IDLE (back-to-back frames, no gap required).
REQ-024 SHALL treat err_clr as having no effect on state, word, or good_count.

Reset
REQ-025 SHALL, while rst_n=1, force state IDLE, word=0x00, word_valid=0, parity_err=0, frame_err=0, good_count=0, timeout counter=0, independent of clk.
REQ-026 SHALL, on reset mid-frame, discard partial data; after rst_n falls, no word_valid until a complete new frame.

Verification
REQ-027 Frame data 0xC6, parity 0, stop 1, ser_en every cycle -> word=0xC6, single word_valid pulse, good_count=1, no errors.
REQ-028 Frame data 0x01 with parity 0 -> parity_err=1, word unchanged, no word_valid; err_clr pulse -> parity_err=0.
REQ-029 Frame 0x5A with stop bit 0 -> frame_err=1, word unchanged; next valid frame 0x0F back-to-back -> word=0x0F, word_valid.
REQ-030 TIMEOUT_CYCLES=4, stop ser_en after 3 data bits for 4 cycles -> frame_err=1, state IDLE; following good frame 0x33 accepted.
REQ-031 256 good frames -> good_count wraps to 0; rst_n pulse mid-frame -> all outputs 0, partial frame never emitted.
REQ-032 PARITY_EN=0, frame 0xFF plus stop 1 (10 bits) -> word=0xFF, word_valid, no parity_err.
